// File: rtl/load_store_unit.sv
// MEM-stage load/store controller for a big-endian, 32-bit-port, byte-addressed data memory.
// Handles one request at a time. Sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int ADDR_W      = 8,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t      state_reg, state_next;
    logic        store_reg, store_next;
    logic [1:0]  size_reg, size_next;
    logic        unsigned_reg, unsigned_next;
    logic [1:0]  off_reg, off_next;
    logic [31:0] wdata_reg, wdata_next;

    logic        req_ready_next, resp_valid_next, resp_error_next;
    logic        mem_read_next, mem_write_next;
    logic [31:0] resp_rdata_next, mem_addr_next, mem_wdata_next;

    logic        accept, req_err;
    logic [4:0]  lane_shift;
    logic [31:0] lane_mask, lane_data, load_ext, merged;

    assign accept = req_valid && req_ready;

    // Errors are decided entirely from the request as it is accepted.
    always_comb begin
        req_err = 1'b0;
        if (req_size == SZ_RSVD)                               req_err = 1'b1;
        if (req_size == SZ_HALF && req_addr[0])                req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)     req_err = 1'b1;
        if (CHECK_RANGE && ((req_addr >> ADDR_W) != 32'd0))    req_err = 1'b1;
    end

    // Big-endian lanes: byte at offset k sits (3-k) bytes up from bit 0.
    always_comb begin
        lane_shift = 5'd0;
        lane_mask  = 32'hFFFF_FFFF;
        if (size_reg == SZ_BYTE) begin
            lane_shift = {~off_reg, 3'b000};
            lane_mask  = 32'h0000_00FF << lane_shift;
        end else if (size_reg == SZ_HALF) begin
            lane_shift = {~off_reg[1], 4'b0000};
            lane_mask  = 32'h0000_FFFF << lane_shift;
        end
        lane_data = mem_rdata >> lane_shift;
        merged    = (mem_rdata & ~lane_mask) | ((wdata_reg << lane_shift) & lane_mask);
        case (size_reg)
            SZ_BYTE: load_ext = {{24{~unsigned_reg & lane_data[7]}}, lane_data[7:0]};
            SZ_HALF: load_ext = {{16{~unsigned_reg & lane_data[15]}}, lane_data[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        store_next      = store_reg;
        size_next       = size_reg;
        unsigned_next   = unsigned_reg;
        off_next        = off_reg;
        wdata_next      = wdata_reg;
        mem_addr_next   = mem_addr;
        mem_wdata_next  = mem_wdata;
        resp_valid_next = 1'b0;
        resp_error_next = 1'b0;
        resp_rdata_next = 32'd0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    store_next    = req_store;
                    size_next     = req_size;
                    unsigned_next = req_unsigned;
                    off_next      = req_addr[1:0];
                    wdata_next    = req_wdata;
                    if (req_err) begin
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        resp_error_next = 1'b1;
                    end else begin
                        mem_addr_next = {req_addr[31:2], 2'b00};
                        if (req_store && req_size == SZ_WORD) begin
                            state_next     = WR;
                            mem_wdata_next = req_wdata;
                        end else begin
                            state_next = RD;
                        end
                    end
                end
            end
            RD: begin
                if (store_reg) begin
                    state_next     = WR;
                    mem_wdata_next = merged;
                end else begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_rdata_next = load_ext;
                end
            end
            WR: begin
                state_next      = RESP;
                resp_valid_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        // Strobes are registered images of the state being entered.
        req_ready_next = (state_next == IDLE);
        mem_read_next  = (state_next == RD);
        mem_write_next = (state_next == WR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            store_reg    <= 1'b0;
            size_reg     <= 2'b00;
            unsigned_reg <= 1'b0;
            off_reg      <= 2'b00;
            wdata_reg    <= 32'd0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_error   <= 1'b0;
            resp_rdata   <= 32'd0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            store_reg    <= store_next;
            size_reg     <= size_next;
            unsigned_reg <= unsigned_next;
            off_reg      <= off_next;
            wdata_reg    <= wdata_next;
            req_ready    <= req_ready_next;
            resp_valid   <= resp_valid_next;
            resp_error   <= resp_error_next;
            resp_rdata   <= resp_rdata_next;
            mem_addr     <= mem_addr_next;
            mem_wdata    <= mem_wdata_next;
            mem_read     <= mem_read_next;
            mem_write    <= mem_write_next;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 256-byte data memory.
// Each transaction is traced on one line; expected values are hand-computed.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:63];
    int          wr_count = 0;
    int          pass = 0;
    int          total = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(8), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[7:2]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    // One request; measures edges from accept to the edge that samples resp_valid.
    task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int nrd, output int nwr, output logic [31:0] wword,
                          output logic [31:0] waddr, output int bad);
        int g;
        lat = 1; rd = 32'hXXXX_XXXX; er = 1'bx; nrd = 0; nwr = 0;
        wword = 32'd0; waddr = 32'd0; bad = 0; g = 0;
        while (!req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!req_ready) bad++;
        req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        while (lat <= 10) begin
            if (req_ready) bad++;
            if (mem_read && mem_write) bad++;
            if (mem_read) nrd++;
            if (mem_write) begin
                nwr++;
                wword = mem_wdata;
                waddr = mem_addr;
            end
            if (resp_valid) begin
                rd = resp_rdata;
                er = resp_error;
                break;
            end
            lat++;
            @(negedge clk);
        end
        @(negedge clk);
        if (!req_ready || resp_valid) bad++;
        $display("txn st=%0b sz=%0d uns=%0b addr=%08h wdata=%08h -> lat=%0d rdata=%08h err=%0b rd=%0d wr=%0d wword=%08h bad=%0d",
                 st, sz, uns, addr, wd, lat, rd, er, nrd, nwr, wword, bad);
    endtask

    task automatic test_reset();
        #1;
        total++; if (req_ready !== 1'b0)  $display("FAIL rst_ready got %0b want 0", req_ready); else pass++;
        total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %0b want 0", resp_valid); else pass++;
        total++; if ({mem_read, mem_write} !== 2'b00) $display("FAIL rst_mem_rw got %b want 00", {mem_read, mem_write}); else pass++;
        total++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || resp_rdata !== 32'd0)
            $display("FAIL rst_data got %08h/%08h/%08h want 0", mem_addr, mem_wdata, resp_rdata); else pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %0b want 1", req_ready); else pass++;
        $display("txn reset released");
    endtask

    task automatic test_word();
        int lat, nrd, nwr, bad; logic [31:0] rd, ww, wa; logic er;
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, lat, rd, er, nrd, nwr, ww, wa, bad);
        total++; if (lat !== 2) $display("FAIL sw_lat got %0d want 2", lat); else pass++;
        total++; if (nwr !== 1 || nrd !== 0) $display("FAIL sw_pulses got rd=%0d wr=%0d want 0/1", nrd, nwr); else pass++;
        total++; if (wa !== 32'h14 || ww !== 32'hDEADBEEF) $display("FAIL sw_write got %08h@%08h want DEADBEEF@00000014", ww, wa); else pass++;
        total++; if (er !== 1'b0 || rd !== 32'd0 || bad !== 0) $display("FAIL sw_resp got err=%0b rdata=%08h bad=%0d want 0/0/0", er, rd, bad); else pass++;
        do_req(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, lat, rd, er, nrd, nwr, ww, wa, bad);
        total++; if (lat !== 2) $display("FAIL lw_lat got %0d want 2", lat); else pass++;
        total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) $display("FAIL lw_data got %08h err=%0b want DEADBEEF 0", rd, er); else pass++;
        total++; if (nrd !== 1 || nwr !== 0 || bad !== 0) $display("FAIL lw_pulses got rd=%0d wr=%0d bad=%0d want 1/0/0", nrd, nwr, bad); else pass++;
    endtask

    task automatic test_byte();
        int lat, nrd, nwr, bad; logic [31:0] rd, ww, wa; logic er;
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344, lat, rd, er, nrd, nwr, ww, wa, bad);
        do_req(1'b1, 2'b00, 1'b0, 32'h15, 32'h123456AA, lat, rd, er, nrd, nwr, ww, wa, bad);
        total++; if (lat !== 3) $display("FAIL sb_lat got %0d want 3", lat); else pass++;
        total++; if (ww !== 32'h11AA3344 || wa !== 32'h14) $display("FAIL sb_merge got %08h@%08h want 11AA3344@00000014", ww, wa); else pass++;
        total++; if (nrd !== 1 || nwr !== 1 || bad !== 0 || er !== 1'b0) $display("FAIL sb_pulses got rd=%0d wr=%0d bad=%0d err=%0b", nrd, nwr, bad, er); else pass++;
        do_req(1'b0, 2'b00, 1'b0, 32'h15, 32'd0, lat, rd, er, nrd, nwr, ww, wa, bad);
        total++; if (rd !== 32'hFFFFFFAA || lat !== 2) $display("FAIL lb_data got %08h lat=%0d want FFFFFFAA 2", rd, lat); else pass++;
        do_req(1'b0, 2'b00, 1'b1, 32'h15, 32'd0, lat, rd, er, nrd, nwr, ww, wa, bad);
        total++; if (rd !== 32'h000000AA) $display("FAIL lbu_data got %08h want 000000AA", rd); else pass++;
        do_req(1'b0, 2'b00, 1'b1, 32'h14, 32'd0, lat, rd, er, nrd, nwr, ww, wa, bad);
        total++; if (rd !== 32'h00000011) $display("FAIL lbu_off0 got %08h want 00000011", rd); else pass++;
    endtask

    task automatic test_half();
        int lat, nrd, nwr, bad; logic [31:0] rd, ww, wa; logic er;
        do_req(1'b1, 2'b01, 1'b0, 32'h16, 32'hABCD8001, lat, rd, er, nrd, nwr, ww, wa, bad);
        total++; if (ww !== 32'h11AA8001 || lat !== 3) $display("FAIL sh_merge got %08h lat=%0d want 11AA8001 3", ww, lat); else pass++;
        do_req(1'b0, 2'b01, 1'b0, 32'h16, 32'd0, lat, rd, er, nrd, nwr, ww, wa, bad);
        total++; if (rd !== 32'hFFFF8001) $display("FAIL lh_data got %08h want FFFF8001", rd); else pass++;
        do_req(1'b0, 2'b01, 1'b1, 32'h14, 32'd0, lat, rd, er, nrd, nwr, ww, wa, bad);
        total++; if (rd !== 32'h000011AA) $display("FAIL lhu_data got %08h want 000011AA", rd); else pass++;
        do_req(1'b0, 2'b00, 1'b0, 32'h17, 32'd0, lat, rd, er, nrd, nwr, ww, wa, bad);
        total++; if (rd !== 32'h00000001) $display("FAIL lb_off3 got %08h want 00000001", rd); else pass++;
    endtask

    task automatic test_errors();
        int lat, nrd, nwr, bad; logic [31:0] rd, ww, wa; logic er;
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic        st [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] ad [4] = '{32'h13, 32'h15, 32'h14, 32'h100};
        for (int i = 0; i < 4; i++) begin
            do_req(st[i], sz[i], 1'b0, ad[i], 32'h5A5A5A5A, lat, rd, er, nrd, nwr, ww, wa, bad);
            total++; if (er !== 1'b1 || lat !== 1) $display("FAIL err%0d_resp got err=%0b lat=%0d want 1 1", i, er, lat); else pass++;
            total++; if (nrd !== 0 || nwr !== 0 || rd !== 32'd0 || bad !== 0)
                $display("FAIL err%0d_side got rd=%0d wr=%0d rdata=%08h bad=%0d want 0/0/0/0", i, nrd, nwr, rd, bad); else pass++;
        end
        total++; if (mem[5] !== 32'h11AA8001) $display("FAIL err_mem got %08h want 11AA8001", mem[5]); else pass++;
    endtask

    task automatic test_reset_abort();
        int lat, nrd, nwr, bad, wc; logic [31:0] rd, ww, wa; logic er;
        do_req(1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFEF00D, lat, rd, er, nrd, nwr, ww, wa, bad);
        wc = wr_count;
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; req_addr = 32'h18; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (mem_read !== 1'b1) $display("FAIL abort_in_rd got mem_read=%0b want 1", mem_read); else pass++;
        #2 rst = 1'b1;
        #1;
        total++; if ({req_ready, resp_valid, resp_error, mem_read, mem_write} !== 5'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0)
            $display("FAIL abort_outputs got %b %08h %08h want 0", {req_ready, resp_valid, resp_error, mem_read, mem_write}, mem_addr, mem_wdata); else pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (req_ready !== 1'b0) $display("FAIL abort_ready_early got %0b want 0", req_ready); else pass++;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL abort_ready got %0b want 1", req_ready); else pass++;
        @(negedge clk);
        total++; if (wr_count !== wc || mem[6] !== 32'hCAFEF00D)
            $display("FAIL abort_mem got writes=%0d word=%08h want %0d CAFEF00D", wr_count, mem[6], wc); else pass++;
        $display("txn reset abort of SB 0x18 done");
    endtask

    task automatic test_back_to_back();
        int lat, nrd, nwr, bad, k, np, last, gapbad, rdy; logic [31:0] rd, ww, wa; logic er;
        logic [31:0] got [4];
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 2'b10, 1'b0, 32'h20 + 32'(4 * i), 32'hA0000000 + 32'(i), lat, rd, er, nrd, nwr, ww, wa, bad);
        k = 0; np = 0; last = -1; gapbad = 0; rdy = 0;
        req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (resp_valid) begin
                if (np < 4) got[np] = resp_rdata;
                if (np > 0 && cyc - last != 3) gapbad++;
                last = cyc;
                np++;
                $display("txn b2b resp %0d rdata=%08h cycle=%0d", np, resp_rdata, cyc);
            end
            if (req_ready && np < 4) rdy++;
            if (req_ready) begin
                if (k < 4) begin
                    req_valid = 1'b1;
                    req_addr  = 32'h20 + 32'(4 * k);
                    k++;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        total++; if (np !== 4) $display("FAIL b2b_count got %0d want 4", np); else pass++;
        total++; if (gapbad !== 0) $display("FAIL b2b_spacing got %0d bad gaps want 0", gapbad); else pass++;
        total++; if (rdy !== 4) $display("FAIL b2b_ready got %0d ready cycles want 4", rdy); else pass++;
        for (int i = 0; i < 4; i++) begin
            total++; if (got[i] !== 32'hA0000000 + 32'(i)) $display("FAIL b2b_data%0d got %08h want %08h", i, got[i], 32'hA0000000 + 32'(i)); else pass++;
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
